// File: rtl/fio_sequencer_if.sv
// fio_sequencer_if: host-side load and dump valid/ready streams
interface fio_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
endinterface

// File: rtl/fio_sequencer.sv
// fio_sequencer: streams init data into the GPU, runs it, then dumps a window of memory lines
module fio_sequencer #(
  parameter int TM_DEPTH = 256,
  parameter int ICACHE_DEPTH = 1024,
  parameter int MEM_DEPTH = 256,
  parameter int SHMEM_DEPTH = 256,
  parameter int DUMP_FIRST = 1,
  parameter int DUMP_LAST = 32,
  localparam int ADDR_W = $clog2(MEM_DEPTH + SHMEM_DEPTH),
  localparam int TW = $clog2(TM_DEPTH) + 1,
  localparam int MW = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [TW-1:0]        tm_count,
  fio_sequencer_if.slave       bus,
  output logic                 busy,
  output logic                 done,
  output logic                 Write_Enable_FIO_TM,
  output logic [28:0]          Write_Data_FIO_TM,
  output logic                 start_FIO_TM,
  output logic                 clear_FIO_TM,
  input  logic                 finished_TM_FIO,
  output logic                 FileIO_Wen_ICache,
  output logic [9:0]           FileIO_Addr_ICache,
  output logic [31:0]          FileIO_Din_ICache,
  output logic                 FIO_MEMWRITE,
  output logic [ADDR_W-1:0]    FIO_ADDR,
  output logic [255:0]         FIO_WRITE_DATA,
  input  logic [255:0]         FIO_READ_DATA,
  output logic                 FIO_CACHE_LAT_WRITE,
  output logic [4:0]           FIO_CACHE_LAT_VALUE,
  output logic [MW-1:0]        FIO_CACHE_MEM_ADDR
);
  localparam int CW = $clog2(ICACHE_DEPTH + MEM_DEPTH + SHMEM_DEPTH + TM_DEPTH) + 1;
  typedef enum logic [3:0] {IDLE, LD_IC, LD_MEM, LD_EMU, LD_TM, RUN, DUMP_ADDR, DUMP_CAP, DUMP_OUT, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, len;
  logic [TW-1:0] tm_n;
  logic [ADDR_W-1:0] line;
  logic [255:0] out_q;
  logic run_arm, ld, xfer, last, go_ok;
  assign ld = state inside {LD_IC, LD_MEM, LD_EMU, LD_TM};
  assign xfer = ld && bus.in_valid;
  assign go_ok = go && (state == IDLE || state == DONE);
  assign len = state == LD_IC ? CW'(ICACHE_DEPTH) : state == LD_MEM ? CW'(MEM_DEPTH + SHMEM_DEPTH) :
               state == LD_EMU ? CW'(MEM_DEPTH) : CW'(tm_n);
  assign last = cnt == len - CW'(1);
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign bus.in_ready = ld;
  assign bus.out_valid = state == DUMP_OUT;
  assign bus.out_data = out_q;
  // next state: load phases advance on their last beat, RUN waits one cycle before honouring finished
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = go ? LD_IC : state;
      LD_IC:      nxt = xfer && last ? LD_MEM : state;
      LD_MEM:     nxt = xfer && last ? LD_EMU : state;
      LD_EMU:     nxt = xfer && last ? (tm_n == '0 ? RUN : LD_TM) : state;
      LD_TM:      nxt = xfer && last ? RUN : state;
      RUN:        nxt = run_arm && finished_TM_FIO ? DUMP_ADDR : state;
      DUMP_ADDR:  nxt = DUMP_CAP;
      DUMP_CAP:   nxt = DUMP_OUT;
      DUMP_OUT:   nxt = bus.out_ready ? (line == ADDR_W'(DUMP_LAST) ? DONE : DUMP_ADDR) : state;
      default:    nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // counters and registered GPU-side outputs; each accepted beat becomes a write one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tm_n <= '0;
      line <= '0;
      run_arm <= 1'b0;
      out_q <= '0;
      clear_FIO_TM <= 1'b0;
      start_FIO_TM <= 1'b0;
      FileIO_Wen_ICache <= 1'b0;
      FileIO_Addr_ICache <= '0;
      FileIO_Din_ICache <= '0;
      FIO_MEMWRITE <= 1'b0;
      FIO_ADDR <= '0;
      FIO_WRITE_DATA <= '0;
      FIO_CACHE_LAT_WRITE <= 1'b0;
      FIO_CACHE_LAT_VALUE <= '0;
      FIO_CACHE_MEM_ADDR <= '0;
      Write_Enable_FIO_TM <= 1'b0;
      Write_Data_FIO_TM <= '0;
    end else begin
      cnt <= go_ok || (xfer && last) ? '0 : xfer ? cnt + CW'(1) : cnt;
      if (go_ok) tm_n <= tm_count;
      run_arm <= state == RUN;
      clear_FIO_TM <= go_ok;
      start_FIO_TM <= state >= RUN && nxt >= RUN;
      FileIO_Wen_ICache <= xfer && state == LD_IC;
      FIO_MEMWRITE <= xfer && state == LD_MEM;
      FIO_CACHE_LAT_WRITE <= xfer && state == LD_EMU;
      Write_Enable_FIO_TM <= xfer && state == LD_TM;
      if (xfer && state == LD_IC) begin
        FileIO_Addr_ICache <= cnt[9:0];
        FileIO_Din_ICache <= bus.in_data[31:0];
      end
      if (xfer && state == LD_MEM) begin
        FIO_ADDR <= cnt[ADDR_W-1:0];
        FIO_WRITE_DATA <= bus.in_data;
      end else if (nxt == DUMP_ADDR) begin
        FIO_ADDR <= state == RUN ? ADDR_W'(DUMP_FIRST) : line + ADDR_W'(1);
        line <= state == RUN ? ADDR_W'(DUMP_FIRST) : line + ADDR_W'(1);
      end
      if (xfer && state == LD_EMU) begin
        FIO_CACHE_MEM_ADDR <= cnt[MW-1:0];
        FIO_CACHE_LAT_VALUE <= bus.in_data[4:0];
      end
      if (xfer && state == LD_TM) Write_Data_FIO_TM <= bus.in_data[28:0];
      if (state == DUMP_CAP) out_q <= FIO_READ_DATA;
    end
  end
endmodule

// File: tb/tb_fio_sequencer.sv
// tb_fio_sequencer: scoreboard bench for load sequencing, run handoff and dump backpressure
module tb_fio_sequencer;
  logic clk = 0, rst = 1, go = 0, finished_TM_FIO = 0;
  logic [8:0] tm_count = '0;
  logic busy, done, Write_Enable_FIO_TM, start_FIO_TM, clear_FIO_TM;
  logic [28:0] Write_Data_FIO_TM;
  logic FileIO_Wen_ICache, FIO_MEMWRITE, FIO_CACHE_LAT_WRITE;
  logic [9:0] FileIO_Addr_ICache;
  logic [31:0] FileIO_Din_ICache;
  logic [8:0] FIO_ADDR;
  logic [255:0] FIO_WRITE_DATA, FIO_READ_DATA;
  logic [4:0] FIO_CACHE_LAT_VALUE;
  logic [7:0] FIO_CACHE_MEM_ADDR;
  logic [255:0] mem [512];
  fio_sequencer_if bus();
  fio_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .tm_count(tm_count), .bus(bus), .busy(busy), .done(done),
    .Write_Enable_FIO_TM(Write_Enable_FIO_TM), .Write_Data_FIO_TM(Write_Data_FIO_TM),
    .start_FIO_TM(start_FIO_TM), .clear_FIO_TM(clear_FIO_TM), .finished_TM_FIO(finished_TM_FIO),
    .FileIO_Wen_ICache(FileIO_Wen_ICache), .FileIO_Addr_ICache(FileIO_Addr_ICache),
    .FileIO_Din_ICache(FileIO_Din_ICache), .FIO_MEMWRITE(FIO_MEMWRITE), .FIO_ADDR(FIO_ADDR),
    .FIO_WRITE_DATA(FIO_WRITE_DATA), .FIO_READ_DATA(FIO_READ_DATA),
    .FIO_CACHE_LAT_WRITE(FIO_CACHE_LAT_WRITE), .FIO_CACHE_LAT_VALUE(FIO_CACHE_LAT_VALUE),
    .FIO_CACHE_MEM_ADDR(FIO_CACHE_MEM_ADDR)
  );
  always #5 clk = ~clk;
  // global+shared memory with one-cycle read latency
  always @(posedge clk) begin
    if (FIO_MEMWRITE) mem[FIO_ADDR] <= FIO_WRITE_DATA;
    FIO_READ_DATA <= mem[FIO_ADDR];
  end
  typedef struct {int kind; int addr; logic [255:0] data;} wr_t;
  wr_t wq[$];
  logic [255:0] dq[$];
  int vecs = 0, miss = 0;
  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic logic [255:0] beat(int b);
    if (b < 1024) return {8{32'hC0DE0000 + 32'(b)}};
    if (b < 1536) return {8{32'(b - 1024)}};
    if (b < 1792) return {8{32'((b - 1536) * 37 + 3)}};
    return {8{32'h0ABC0000 + 32'(b - 1792)}};
  endfunction
  function automatic void push_exp(int b);
    wr_t w;
    logic [255:0] d = beat(b);
    w.kind = b < 1024 ? 0 : b < 1536 ? 1 : b < 1792 ? 2 : 3;
    w.addr = b < 1024 ? b : b < 1536 ? b - 1024 : b < 1792 ? b - 1536 : 0;
    w.data = w.kind == 0 ? {224'b0, d[31:0]} : w.kind == 1 ? d : w.kind == 2 ? {251'b0, d[4:0]} : {227'b0, d[28:0]};
    wq.push_back(w);
  endfunction
  function automatic void push_dump();
    for (int k = 1; k <= 32; k++) dq.push_back({8{32'(k)}});
  endfunction
  function automatic void check_wr(int kind, int addr, logic [255:0] data);
    wr_t w;
    if (wq.size() == 0) begin
      vecs++;
      miss++;
      $display("FAIL unexpected_write: got kind %0d addr %0d expected no write", kind, addr);
    end else begin
      w = wq.pop_front();
      chk("write_kind_addr", 256'({32'(kind), 32'(addr)}), 256'({32'(w.kind), 32'(w.addr)}));
      chk("write_data", data, w.data);
    end
  endfunction
  logic hold_p = 0, hs_p = 0;
  logic [255:0] data_p = '0;
  // monitor: pops expected writes and dump beats as the DUT presents them
  always begin
    @(negedge clk);
    #2;
    if (FileIO_Wen_ICache) check_wr(0, int'(FileIO_Addr_ICache), 256'(FileIO_Din_ICache));
    if (FIO_MEMWRITE) check_wr(1, int'(FIO_ADDR), FIO_WRITE_DATA);
    if (FIO_CACHE_LAT_WRITE) check_wr(2, int'(FIO_CACHE_MEM_ADDR), 256'(FIO_CACHE_LAT_VALUE));
    if (Write_Enable_FIO_TM) check_wr(3, 0, 256'(Write_Data_FIO_TM));
    if (hold_p) begin
      chk("out_hold_valid", 256'(bus.out_valid), 256'(1));
      chk("out_hold_data", bus.out_data, data_p);
    end
    if (hs_p) chk("out_gap", 256'(bus.out_valid), 256'(0));
    if (bus.out_valid && bus.out_ready) begin
      if (dq.size() == 0) begin
        vecs++;
        miss++;
        $display("FAIL unexpected_beat: got %0h expected no beat", bus.out_data);
      end else chk("dump_data", bus.out_data, dq.pop_front());
    end
    hold_p = bus.out_valid && !bus.out_ready;
    hs_p = bus.out_valid && bus.out_ready;
    data_p = bus.out_data;
  end
  task automatic start_go(int t);
    go = 1;
    tm_count = 9'(t);
    @(negedge clk);
    go = 0;
    chk("clear_pulse", 256'(clear_FIO_TM), 256'(1));
    chk("start_low_after_go", 256'(start_FIO_TM), 256'(0));
    chk("busy_after_go", 256'(busy), 256'(1));
  endtask
  task automatic load(int tm, bit bub, int stop, bit gp);
    int total = 1792 + tm;
    int b = 0;
    int it = 0;
    bit gprev = 0;
    while (b < total && b < stop) begin
      if (it == 1) chk("clear_one_cycle", 256'(clear_FIO_TM), 256'(0));
      if (gprev) chk("go_ignored", 256'(clear_FIO_TM), 256'(0));
      bus.in_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data = beat(b);
      go = gp && b == 50;
      gprev = go;
      if (bus.in_valid) begin
        push_exp(b);
        b++;
      end
      it++;
      @(negedge clk);
    end
    bus.in_valid = 0;
    go = 0;
  endtask
  task automatic dump(bit hold);
    for (int l = 1; l <= 32; l++) begin
      int n = 0;
      if (hold && l == 7) bus.out_ready = 0;
      while (!bus.out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus.out_valid) begin
        chk("dump_timeout", 256'(0), 256'(1));
        bus.out_ready = 1;
        return;
      end
      if (hold && l == 7) begin
        repeat (4) @(negedge clk);
        bus.out_ready = 1;
      end
      @(negedge clk);
    end
    chk("done_after_dump", 256'(done), 256'(1));
    chk("busy_after_dump", 256'(busy), 256'(0));
    chk("start_in_done", 256'(start_FIO_TM), 256'(1));
  endtask
  task automatic check_idle(string name);
    chk(name, 256'({busy, done, bus.in_ready, bus.out_valid, Write_Enable_FIO_TM, Write_Data_FIO_TM,
                    start_FIO_TM, clear_FIO_TM, FileIO_Wen_ICache, FileIO_Addr_ICache, FileIO_Din_ICache,
                    FIO_MEMWRITE, FIO_ADDR, FIO_CACHE_LAT_WRITE, FIO_CACHE_LAT_VALUE, FIO_CACHE_MEM_ADDR}), 256'(0));
    chk({name, "_wdata"}, FIO_WRITE_DATA, 256'(0));
    chk({name, "_out_data"}, bus.out_data, 256'(0));
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 0;
    @(negedge clk);
    start_go(5);
    load(5, 0, 1125, 0);
    rst = 1;
    @(negedge clk);
    check_idle("reset_mid_mem");
    chk("queue_after_reset", 256'(wq.size()), 256'(0));
    rst = 0;
    @(negedge clk);
    start_go(5);
    load(5, 0, 1 << 30, 0);
    chk("tm_last_write", 256'(Write_Enable_FIO_TM), 256'(1));
    chk("start_before_last_write", 256'(start_FIO_TM), 256'(0));
    @(negedge clk);
    chk("start_rise", 256'(start_FIO_TM), 256'(1));
    chk("tm_we_after", 256'(Write_Enable_FIO_TM), 256'(0));
    finished_TM_FIO = 1;
    push_dump();
    dump(1);
    push_dump();
    start_go(0);
    load(0, 0, 1 << 30, 0);
    chk("tm0_last_emu_write", 256'(FIO_CACHE_LAT_WRITE), 256'(1));
    chk("tm0_run_in_ready", 256'(bus.in_ready), 256'(0));
    chk("tm0_run_busy", 256'(busy), 256'(1));
    chk("run_entry_addr", 256'(FIO_ADDR), 256'(511));
    @(negedge clk);
    chk("finished_ignored_entry", 256'(FIO_ADDR), 256'(511));
    chk("tm0_start_rise", 256'(start_FIO_TM), 256'(1));
    @(negedge clk);
    chk("dump_addr_second_cycle", 256'(FIO_ADDR), 256'(1));
    dump(0);
    finished_TM_FIO = 0;
    start_go(3);
    load(3, 1, 1 << 30, 1);
    bus.in_valid = 1;
    repeat (5) @(negedge clk);
    chk("run_wait_no_out", 256'(bus.out_valid), 256'(0));
    chk("run_wait_in_ready", 256'(bus.in_ready), 256'(0));
    chk("run_wait_busy", 256'(busy), 256'(1));
    bus.in_valid = 0;
    push_dump();
    finished_TM_FIO = 1;
    dump(0);
    finished_TM_FIO = 0;
    @(negedge clk);
    chk("write_queue_empty", 256'(wq.size()), 256'(0));
    chk("dump_queue_empty", 256'(dq.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
